// File: rtl/right_shift_serializer.sv
// Multiplier-operand serializer: parallel load, one right shift per enabled cycle,
// LSB presented to add/skip logic, done pulse after WL bits. Define ARITH_SHIFT_EN for sign fill.
module right_shift_serializer #(
    parameter  int WL = 4,
    localparam int CW = $clog2(WL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    output logic          load_ready,
    input  logic [WL-1:0] in,
    input  logic          shift_en,
    output logic          bit_out,
    output logic          bit_valid,
    output logic [WL-1:0] out,
    output logic [CW-1:0] count,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [WL-1:0] data_reg, data_next;
    logic [CW-1:0] count_reg, count_next;
    logic          fill;

`ifdef ARITH_SHIFT_EN
    assign fill = data_reg[WL-1];
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        unique case (state_reg)
            IDLE, DONE: begin
                // Load takes priority over shift_en; DONE without a load falls back to IDLE.
                if (load) begin
                    data_next  = in;
                    count_next = '0;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    data_next  = {fill, data_reg[WL-1:1]};
                    count_next = count_reg + 1'b1;
                    if (count_reg == CW'(WL - 1))
                        state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_ready = (state_reg != SHIFT);
    assign bit_valid  = (state_reg == SHIFT);
    assign done       = (state_reg == DONE);
    assign bit_out    = data_reg[0];
    assign out        = data_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_right_shift_serializer.sv
// Randomized + directed bench for right_shift_serializer against an operand/bit-count model.
module tb_right_shift_serializer;
    localparam int WL = 4;
    localparam int CW = $clog2(WL + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic          shift_en = 1'b0;
    logic [WL-1:0] in = '0;
    logic          load_ready, bit_out, bit_valid, done;
    logic [WL-1:0] out;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    // Model: the operand as loaded, how many bits have been consumed, and two phase flags.
    logic [WL-1:0] m_op = '0;
    int            m_k = 0;
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;

    right_shift_serializer #(.WL(WL)) dut (
        .clk(clk), .rst(rst), .load(load), .load_ready(load_ready), .in(in),
        .shift_en(shift_en), .bit_out(bit_out), .bit_valid(bit_valid),
        .out(out), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WL-1:0] exp_out();
        logic [WL-1:0] r;
`ifdef ARITH_SHIFT_EN
        r = WL'($signed(m_op) >>> m_k);
`else
        r = m_op >> m_k;
`endif
        return r;
    endfunction

    task automatic check_all(input string tag);
        logic [WL-1:0] e;
        e = exp_out();
        chk({tag, ".out"}, 32'(out), 32'(e));
        chk({tag, ".count"}, 32'(count), 32'(m_k));
        chk({tag, ".flags"}, {28'd0, bit_out, bit_valid, load_ready, done},
            {28'd0, e[0], m_busy, !m_busy, m_done});
    endtask

    // Drive inputs (at negedge), advance one clock, update model, check at the next negedge.
    task automatic cycle(input logic l, input logic se, input logic [WL-1:0] d, input string tag);
        load = l; shift_en = se; in = d;
        @(posedge clk);
        if (!m_busy) begin
            m_done = 1'b0;
            if (l) begin
                m_op = d; m_k = 0; m_busy = 1'b1;
            end
        end else if (se) begin
            m_k++;
            if (m_k == WL) begin
                m_busy = 1'b0; m_done = 1'b1;
            end
        end
        @(negedge clk);
        check_all(tag);
        $display("%s: load=%0b se=%0b in=%b -> out=%b cnt=%0d bit=%0b v=%0b rdy=%0b done=%0b",
                 tag, l, se, d, out, count, bit_out, bit_valid, load_ready, done);
    endtask

    task automatic model_reset();
        m_op = '0; m_k = 0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    initial begin
        logic [6:0] stall_pat;
        stall_pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1

        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // Basic shift of 1011
        cycle(1'b1, 1'b0, 4'b1011, "basic_load");
        for (int i = 0; i < WL; i++) cycle(1'b0, 1'b1, '0, "basic_shift");
        cycle(1'b0, 1'b1, '0, "basic_idle");

        // Stall pattern on 0110
        cycle(1'b1, 1'b0, 4'b0110, "stall_load");
        for (int i = 0; i < 7; i++) cycle(1'b0, stall_pat[i], '0, "stall");
        cycle(1'b0, 1'b0, '0, "stall_idle");

        // Load during SHIFT is ignored
        cycle(1'b1, 1'b0, 4'b1001, "ign_load");
        cycle(1'b0, 1'b1, '0, "ign_shift1");
        cycle(1'b1, 1'b0, 4'b1111, "ign_reload");
        chk("ign_out_0100", 32'(out), 32'h4);
        cycle(1'b1, 1'b1, 4'b1111, "ign_shift2");
        chk("ign_count_2", 32'(count), 32'd2);
        cycle(1'b0, 1'b1, '0, "ign_shift3");
        cycle(1'b0, 1'b1, '0, "ign_shift4");

        // Back-to-back: reload in the DONE cycle
        chk("b2b_in_done", 32'(done), 32'd1);
        cycle(1'b1, 1'b1, 4'b0011, "b2b_load");
        chk("b2b_bit", 32'(bit_out), 32'd1);

        // Reset mid-operation, asserted between edges
        cycle(1'b1, 1'b0, 4'b1110, "rst_load");
        cycle(1'b0, 1'b1, '0, "rst_shift1");
        cycle(1'b0, 1'b1, '0, "rst_shift2");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, "rst_stay_idle");

        // Sign-fill case 1010 (logical or arithmetic depending on build)
        cycle(1'b1, 1'b0, 4'b1010, "fill_load");
        for (int i = 0; i < WL; i++) cycle(1'b0, 1'b1, '0, "fill_shift");
`ifdef ARITH_SHIFT_EN
        chk("fill_final", 32'(out), 32'hF);
`else
        chk("fill_final", 32'(out), 32'h0);
`endif
        cycle(1'b0, 1'b0, '0, "fill_idle");

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  WL'($urandom), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
